// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter feeding one 4-phase handshake CDC channel from NUM_REQ requesters.
// One payload is captured per grant and held on chan_data until the channel handshake completes.
module cdc_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         chan_data,
  output logic                          chan_valid,
  input  logic                          chan_ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          xfer_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] sel;
  logic            grant;

  // First requesting index found searching upward from last+1, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    int              cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      idx  = ID_W'(cand);
      if (!found && v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  // A stale acknowledge blocks arbitration until the channel has returned to zero.
  assign sel   = rr_pick(req_valid, last_grant);
  assign grant = (state == IDLE) && !reset && !chan_ack && (|req_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)     state_nxt = SEND;
      SEND:    if (chan_ack)  state_nxt = DRAIN;
      DRAIN:   if (!chan_ack) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[sel] = 1'b1;
    end
    chan_valid = (state == SEND);
    busy       = (state != IDLE);
  end

  // Payload and id change only on a grant edge; the counter steps as SEND sees the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_data  <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      xfer_count <= '0;
    end else begin
      if (grant) begin
        chan_data  <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        grant_id   <= sel;
        last_grant <= sel;
      end
      if ((state == SEND) && chan_ack) begin
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

endmodule
